// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between datapath hazard sources and the stall/flush controller.
// The datapath drives the causes; the controller returns per-stage stall/flush and status.
interface pipe_hazard_ctrl_if #(
  parameter int NSTAGES = 5,
  parameter int CNTW    = 32
);
  localparam int SELW = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;

  logic [NSTAGES-1:0] StallCause;
  logic [NSTAGES-1:0] FlushCause;
  logic [SELW-1:0]    CntSel;
  logic               CntClr;
  logic               WdogClr;
  logic [NSTAGES-1:0] Stall;
  logic [NSTAGES-1:0] Flush;
  logic [CNTW-1:0]    CntRd;
  logic               WdogTimeout;
  logic               WdogFlag;

  modport master (
    output StallCause, FlushCause, CntSel, CntClr, WdogClr,
    input  Stall, Flush, CntRd, WdogTimeout, WdogFlag
  );

  modport slave (
    input  StallCause, FlushCause, CntSel, CntClr, WdogClr,
    output Stall, Flush, CntRd, WdogTimeout, WdogFlag
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for an in-order pipeline: merges per-stage causes into register
// enables/clears, keeps saturating per-stage stall counters and a last-stage stall watchdog.
module pipe_hazard_ctrl #(
  parameter int NSTAGES    = 5,
  parameter int CNTW       = 32,
  parameter int WDOG_LIMIT = 4096
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz
);
  localparam int SELW = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
  localparam int WDW  = (WDOG_LIMIT > 1) ? $clog2(WDOG_LIMIT + 1) : 1;
  localparam logic [SELW:0]     NST_W   = (SELW + 1)'(NSTAGES);
  localparam logic [WDW-1:0]    LIMIT_W = WDW'(WDOG_LIMIT);
  localparam logic [NSTAGES-1:0] RESET_FLUSH = ~(NSTAGES)'(1);

  typedef enum logic [1:0] {IDLE, COUNT, EXPIRED} wdState_t;

  logic [NSTAGES-1:0] gated;
  logic [NSTAGES-1:0] stallRaw;
  logic [NSTAGES-1:0] flushRaw;
  logic [CNTW-1:0]    cntReg  [NSTAGES];
  logic [CNTW-1:0]    cntNext [NSTAGES];
  logic               unusedFlush0;

  wdState_t           stateReg, stateNext;
  logic [WDW-1:0]     wdogCntReg, wdogCntNext, wdogInc;
  logic               flagReg, flagNext;
  logic               timeout;
  logic               lastStall;

  assign unusedFlush0 = hz.FlushCause[0];

  // A flush in a stage overrides its own stall request; Fetch cannot be flushed.
  genvar gi;
  generate
    for (gi = 0; gi < NSTAGES; gi++) begin : g_cause
      if (gi == 0) begin : g_fetch
        assign gated[gi]    = hz.StallCause[gi];
        assign flushRaw[gi] = 1'b0;
      end else begin : g_later
        assign gated[gi]    = hz.StallCause[gi] & ~hz.FlushCause[gi];
        assign flushRaw[gi] = (stallRaw[gi-1] & ~stallRaw[gi]) | hz.FlushCause[gi];
      end
    end
  endgenerate

  // A stall in any stage holds every earlier stage as well.
  always_comb begin
    stallRaw = '0;
    stallRaw[NSTAGES-1] = gated[NSTAGES-1];
    for (int i = NSTAGES - 2; i >= 0; i--) begin
      stallRaw[i] = gated[i] | stallRaw[i+1];
    end
  end

  assign hz.Stall = reset ? '0 : stallRaw;
  assign hz.Flush = reset ? RESET_FLUSH : flushRaw;

  generate
    for (gi = 0; gi < NSTAGES; gi++) begin : g_cnt
      assign cntNext[gi] = hz.CntClr ? '0 :
                           ((stallRaw[gi] & ~flushRaw[gi]) && (cntReg[gi] != '1)) ?
                           cntReg[gi] + 1'b1 : cntReg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSTAGES; i++) begin
      if (reset) cntReg[i] <= '0;
      else       cntReg[i] <= cntNext[i];
    end
  end

  assign hz.CntRd = (!reset && ({1'b0, hz.CntSel} < NST_W)) ? cntReg[hz.CntSel] : '0;

  // Watchdog: wdogInc is the length of the stall run including the current cycle.
  assign lastStall = stallRaw[NSTAGES-1] & ~reset;

  always_comb begin
    stateNext   = stateReg;
    wdogCntNext = wdogCntReg;
    timeout     = 1'b0;
    wdogInc     = (stateReg == IDLE) ? WDW'(1) : wdogCntReg + 1'b1;
    case (stateReg)
      IDLE: begin
        if ((WDOG_LIMIT != 0) && lastStall) begin
          wdogCntNext = wdogInc;
          if (wdogInc == LIMIT_W) begin
            stateNext = EXPIRED;
            timeout   = 1'b1;
          end else begin
            stateNext = COUNT;
          end
        end
      end
      COUNT: begin
        if (!lastStall) begin
          stateNext   = IDLE;
          wdogCntNext = '0;
        end else begin
          wdogCntNext = wdogInc;
          if (wdogInc == LIMIT_W) begin
            stateNext = EXPIRED;
            timeout   = 1'b1;
          end
        end
      end
      EXPIRED: begin
        if (!lastStall) begin
          stateNext   = IDLE;
          wdogCntNext = '0;
        end
      end
      default: begin
        stateNext   = IDLE;
        wdogCntNext = '0;
      end
    endcase
    flagNext = timeout ? 1'b1 : (hz.WdogClr ? 1'b0 : flagReg);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= IDLE;
      wdogCntReg <= '0;
      flagReg    <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      wdogCntReg <= wdogCntNext;
      flagReg    <= flagNext;
    end
  end

  assign hz.WdogTimeout = timeout;
  assign hz.WdogFlag    = flagReg & ~reset;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a behavioural model built
// from per-stage OR-reductions, integer counters and a stall-run length.
module tb_pipe_hazard_ctrl;
  localparam int N   = 5;
  localparam int W   = 4;
  localparam int LIM = 8;
  localparam int MAXC = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NSTAGES(N), .CNTW(W)) hz ();

  pipe_hazard_ctrl #(.NSTAGES(N), .CNTW(W), .WDOG_LIMIT(LIM)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  int compared   = 0;
  int mismatched = 0;
  int txn        = 0;

  // model state
  int mcnt [N];
  int run;
  bit mflag;

  // expected outputs for the current cycle
  logic [N-1:0] eStall, eFlush, rawStall, rawFlush;
  logic [W-1:0] eCntRd;
  logic         ePulse, eFlag;
  logic         lastRst, lastCclr, lastWclr;

  task automatic apply(input logic rst, input logic [N-1:0] sc, input logic [N-1:0] fc,
                       input logic [2:0] sel, input logic cclr, input logic wclr);
    bit g [N];
    @(negedge clk);
    reset         = rst;
    hz.StallCause = sc;
    hz.FlushCause = fc;
    hz.CntSel     = sel;
    hz.CntClr     = cclr;
    hz.WdogClr    = wclr;
    lastRst = rst; lastCclr = cclr; lastWclr = wclr;
    for (int i = 0; i < N; i++) g[i] = sc[i] && (i == 0 || !fc[i]);
    for (int i = 0; i < N; i++) begin
      rawStall[i] = 1'b0;
      for (int j = i; j < N; j++) if (g[j]) rawStall[i] = 1'b1;
    end
    rawFlush[0] = 1'b0;
    for (int i = 1; i < N; i++) rawFlush[i] = (rawStall[i-1] && !rawStall[i]) || fc[i];
    eStall = rst ? '0 : rawStall;
    eFlush = rst ? 5'b11110 : rawFlush;
    ePulse = !rst && (LIM != 0) && rawStall[N-1] && (run + 1 == LIM);
    eCntRd = (!rst && sel < N) ? W'(mcnt[sel]) : '0;
    eFlag  = !rst && mflag;
    #1;
    txn++;
    $display("txn %0d rst=%b sc=%b fc=%b sel=%0d clr=%b wclr=%b -> stall=%b flush=%b cnt=%0d to=%b flag=%b",
             txn, rst, sc, fc, sel, cclr, wclr, hz.Stall, hz.Flush, hz.CntRd, hz.WdogTimeout, hz.WdogFlag);
  endtask

  task automatic advance();
    @(posedge clk);
    if (lastRst) begin
      for (int i = 0; i < N; i++) mcnt[i] = 0;
      run = 0; mflag = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (lastCclr) mcnt[i] = 0;
        else if (rawStall[i] && !rawFlush[i] && mcnt[i] < MAXC) mcnt[i]++;
      end
      if (ePulse) mflag = 1;
      else if (lastWclr) mflag = 0;
      run = rawStall[N-1] ? run + 1 : 0;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, N'($urandom), N'($urandom), 3'($urandom), 1'b0, 1'b0);
      compared++;
      if ({hz.Stall, hz.Flush, hz.CntRd, hz.WdogTimeout, hz.WdogFlag} !== {5'b00000, 5'b11110, 4'd0, 1'b0, 1'b0}) begin
        mismatched++;
        $display("FAIL reset_state: got stall=%b flush=%b cnt=%0d to=%b flag=%b, want 00000 11110 0 0 0",
                 hz.Stall, hz.Flush, hz.CntRd, hz.WdogTimeout, hz.WdogFlag);
      end
      advance();
    end
  endtask

  task automatic test_directed();
    apply(1'b0, 5'b00000, 5'b00000, 3'd2, 1'b1, 1'b0);
    advance();
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 5'b00100, 5'b00000, 3'd2, 1'b0, 1'b0);
      compared++;
      if ({hz.Stall, hz.Flush, hz.CntRd} !== {5'b00111, 5'b01000, W'(k)}) begin
        mismatched++;
        $display("FAIL mid_stall: got stall=%b flush=%b cnt=%0d, want 00111 01000 %0d", hz.Stall, hz.Flush, hz.CntRd, k);
      end
      advance();
    end
    apply(1'b0, 5'b00100, 5'b00100, 3'd2, 1'b0, 1'b0);
    compared++;
    if ({hz.Stall, hz.Flush} !== {5'b00000, 5'b00100}) begin
      mismatched++;
      $display("FAIL flush_beats_stall: got stall=%b flush=%b, want 00000 00100", hz.Stall, hz.Flush);
    end
    advance();
    apply(1'b0, 5'b10000, 5'b00110, 3'd4, 1'b0, 1'b0);
    compared++;
    if ({hz.Stall, hz.Flush} !== {5'b11111, 5'b00110}) begin
      mismatched++;
      $display("FAIL wb_stall_flush: got stall=%b flush=%b, want 11111 00110", hz.Stall, hz.Flush);
    end
    advance();
    apply(1'b0, 5'b00000, 5'b00000, 3'd6, 1'b0, 1'b0);
    compared++;
    if (hz.CntRd !== '0) begin
      mismatched++;
      $display("FAIL sel_out_of_range: got %0d want 0", hz.CntRd);
    end
    advance();
  endtask

  task automatic test_random();
    bit burst;
    logic [N-1:0] sc, fc;
    for (int k = 0; k < 200; k++) begin
      if (k % 16 == 0) burst = ($urandom_range(0, 1) == 1);
      sc = N'($urandom);
      fc = N'($urandom) & N'($urandom);
      if (burst) begin sc[N-1] = 1'b1; fc[N-1] = 1'b0; end
      apply($urandom_range(0, 60) == 0, sc, fc, 3'($urandom_range(0, 7)),
            $urandom_range(0, 12) == 0, $urandom_range(0, 10) == 0);
      compared++;
      if ({hz.Stall, hz.Flush, hz.CntRd, hz.WdogTimeout, hz.WdogFlag} !== {eStall, eFlush, eCntRd, ePulse, eFlag}) begin
        mismatched++;
        $display("FAIL random_%0d: got stall=%b flush=%b cnt=%0d to=%b flag=%b, want %b %b %0d %b %b", k,
                 hz.Stall, hz.Flush, hz.CntRd, hz.WdogTimeout, hz.WdogFlag, eStall, eFlush, eCntRd, ePulse, eFlag);
      end
      advance();
    end
  endtask

  task automatic test_watchdog();
    int pulses, at;
    apply(1'b1, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0);
    advance();
    for (int pass = 0; pass < 2; pass++) begin
      pulses = 0; at = -1;
      for (int k = 1; k <= (pass == 0 ? 20 : 8); k++) begin
        apply(1'b0, 5'b10000, 5'b00000, 3'd4, 1'b0, 1'b0);
        if (hz.WdogTimeout === 1'b1) begin pulses++; at = k; end
        compared++;
        if ({hz.WdogTimeout, hz.WdogFlag} !== {ePulse, eFlag}) begin
          mismatched++;
          $display("FAIL wdog_cycle_%0d: got to=%b flag=%b, want %b %b", k, hz.WdogTimeout, hz.WdogFlag, ePulse, eFlag);
        end
        advance();
      end
      compared++;
      if (pulses != 1 || at != LIM) begin
        mismatched++;
        $display("FAIL wdog_pulse_%0d: got %0d pulses at cycle %0d, want 1 at %0d", pass, pulses, at, LIM);
      end
      apply(1'b0, 5'b00000, 5'b00000, 3'd4, 1'b0, 1'b1);
      compared++;
      if (hz.WdogFlag !== 1'b1) begin
        mismatched++;
        $display("FAIL wdog_flag_sticky: got %b want 1", hz.WdogFlag);
      end
      advance();
      apply(1'b0, 5'b00000, 5'b00000, 3'd4, 1'b0, 1'b0);
      compared++;
      if (hz.WdogFlag !== 1'b0) begin
        mismatched++;
        $display("FAIL wdog_flag_clear: got %b want 0", hz.WdogFlag);
      end
      advance();
    end
  endtask

  task automatic test_saturation();
    apply(1'b0, 5'b00000, 5'b00000, 3'd1, 1'b1, 1'b0);
    advance();
    for (int k = 0; k < 20; k++) begin
      apply(1'b0, 5'b00010, 5'b00000, 3'd1, 1'b0, 1'b0);
      advance();
    end
    apply(1'b0, 5'b00010, 5'b00000, 3'd1, 1'b1, 1'b0);
    compared++;
    if (hz.CntRd !== 4'd15) begin
      mismatched++;
      $display("FAIL cnt_saturate: got %0d want 15", hz.CntRd);
    end
    advance();
    apply(1'b0, 5'b00010, 5'b00000, 3'd1, 1'b0, 1'b0);
    compared++;
    if (hz.CntRd !== 4'd0) begin
      mismatched++;
      $display("FAIL cnt_clear_beats_inc: got %0d want 0", hz.CntRd);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 10; k++) begin
      apply(1'b0, 5'b10100, 5'b00000, 3'd2, 1'b0, 1'b0);
      advance();
    end
    apply(1'b1, 5'b10100, 5'b00000, 3'd2, 1'b0, 1'b0);
    compared++;
    if ({hz.Stall, hz.Flush} !== {5'b00000, 5'b11110}) begin
      mismatched++;
      $display("FAIL reset_mid_outputs: got stall=%b flush=%b, want 00000 11110", hz.Stall, hz.Flush);
    end
    advance();
    apply(1'b0, 5'b00000, 5'b00000, 3'd2, 1'b0, 1'b0);
    compared++;
    if ({hz.CntRd, hz.WdogFlag} !== {4'd0, 1'b0} || mflag) begin
      mismatched++;
      $display("FAIL reset_mid_state: got cnt=%0d flag=%b, want 0 0", hz.CntRd, hz.WdogFlag);
    end
    advance();
  endtask

  initial begin
    reset = 1'b1;
    hz.StallCause = '0; hz.FlushCause = '0; hz.CntSel = '0; hz.CntClr = 1'b0; hz.WdogClr = 1'b0;
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    run = 0; mflag = 0;
    test_reset();
    test_directed();
    test_random();
    test_watchdog();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
